// File: rtl/spi_mmio_pkg.sv
// rtl/spi_mmio_pkg.sv - SPI MMIO register map, bit positions and sequencer states
// Shared definitions for spi_mmio_arbiter and its helpers.
package spi_mmio_pkg;

    // Register offsets from the SPI block base address
    localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
    localparam logic [31:0] OFF_TXDATA = 32'h0000_0004;
    localparam logic [31:0] OFF_RXDATA = 32'h0000_0008;
    localparam logic [31:0] OFF_STATUS = 32'h0000_000C;

    // CTRL fields
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_START_BIT  = 1;
    localparam int CTRL_CLKDIV_LSB = 8;

    // STATUS fields (DONE is write-1-to-clear)
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TX,
        ST_WR_TX,
        ST_WR_CTRL,
        ST_POLL,
        ST_RD_RX,
        ST_CLR,
        ST_ABORT
    } state_e;

    function automatic logic [31:0] ctrl_word(input logic [7:0] clkdiv,
                                              input logic       en,
                                              input logic       start);
        logic [31:0] w;
        w = '0;
        w[CTRL_CLKDIV_LSB +: 8] = clkdiv;
        w[CTRL_EN_BIT]          = en;
        w[CTRL_START_BIT]       = start;
        return w;
    endfunction

endpackage

// File: rtl/spi_mmio_arbiter_rr_arb2.sv
// rtl/spi_mmio_arbiter_rr_arb2.sv - two-input round-robin pick
// Ports: req_i (requests), last_owner_i (previous burst owner),
//        valid_o (any request), pick_o (index of the chosen requester).
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       valid_o,
    output logic       pick_o
);

    assign valid_o = |req_i;
    // On a tie the requester that did not own the previous burst wins
    assign pick_o  = (&req_i) ? ~last_owner_i : req_i[1];

endmodule

// File: rtl/spi_mmio_arbiter.sv
// rtl/spi_mmio_arbiter.sv - round-robin sequencer sharing the SPI MMIO block between two byte streams
// Ports: clk/resetn; cfg_clkdiv_i latched per burst; req_i/gnt_o burst arbitration;
//        tx_valid_i/tx_data_i/tx_ready_o byte input per requester; rx_valid_o/rx_data_o
//        received byte; err_o timeout pulse; m_* single-cycle MMIO master port.
module spi_mmio_arbiter #(
    parameter logic [31:0] SPI_BASE = 32'h2000_1000,
    parameter logic [15:0] TIMEOUT  = 16'd4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  cfg_clkdiv_i,
    input  logic [1:0]  req_i,
    output logic [1:0]  gnt_o,
    input  logic [1:0]  tx_valid_i,
    input  logic [15:0] tx_data_i,
    output logic [1:0]  tx_ready_o,
    output logic [1:0]  rx_valid_o,
    output logic [7:0]  rx_data_o,
    output logic [1:0]  err_o,
    output logic        m_valid_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wmask_o,
    input  logic [31:0] m_rdata_i
);
    import spi_mmio_pkg::*;

    state_e      state_q;
    logic        owner_q;
    logic        last_owner_q;
    logic [1:0]  gnt_q;
    logic [7:0]  clkdiv_q;
    logic [7:0]  byte_q;
    logic [15:0] cnt_q;
    logic [7:0]  rx_data_q;
    logic [1:0]  rx_valid_q;
    logic [1:0]  err_q;

    logic        arb_valid;
    logic        arb_pick;
    logic [1:0]  owner_oh;
    logic        unused_rdata;

    rr_arb2 u_arb (
        .req_i        (req_i),
        .last_owner_i (last_owner_q),
        .valid_o      (arb_valid),
        .pick_o       (arb_pick)
    );

    assign owner_oh     = owner_q ? 2'b10 : 2'b01;
    assign unused_rdata = ^{m_rdata_i[31:8], m_rdata_i[STATUS_BUSY_BIT]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
            clkdiv_q     <= 8'h00;
            byte_q       <= 8'h00;
            cnt_q        <= 16'd0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 2'b00;
            err_q        <= 2'b00;
        end else begin
            rx_valid_q <= 2'b00;
            err_q      <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        owner_q  <= arb_pick;
                        gnt_q    <= arb_pick ? 2'b10 : 2'b01;
                        clkdiv_q <= cfg_clkdiv_i;
                        state_q  <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    // A byte offered in the same cycle the request drops still goes out
                    if (tx_valid_i[owner_q]) begin
                        byte_q  <= owner_q ? tx_data_i[15:8] : tx_data_i[7:0];
                        state_q <= ST_WR_TX;
                    end else if (!req_i[owner_q]) begin
                        gnt_q        <= 2'b00;
                        last_owner_q <= owner_q;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_WR_TX:   state_q <= ST_WR_CTRL;
                ST_WR_CTRL: begin
                    cnt_q   <= 16'd0;
                    state_q <= ST_POLL;
                end
                ST_POLL: begin
                    if (m_rdata_i[STATUS_DONE_BIT]) begin
                        state_q <= ST_RD_RX;
                    end else if (cnt_q == TIMEOUT - 16'd1) begin
                        err_q   <= owner_oh;
                        state_q <= ST_ABORT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_RD_RX: begin
                    rx_data_q  <= m_rdata_i[7:0];
                    rx_valid_q <= owner_oh;
                    state_q    <= ST_CLR;
                end
                ST_CLR:     state_q <= ST_WAIT_TX;
                ST_ABORT: begin
                    gnt_q        <= 2'b00;
                    last_owner_q <= owner_q;
                    state_q      <= ST_IDLE;
                end
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Bus access and TX accept are decoded from the registered state
    always_comb begin
        tx_ready_o = 2'b00;
        m_valid_o  = 1'b0;
        m_addr_o   = 32'h0;
        m_wdata_o  = 32'h0;
        m_wmask_o  = 4'b0000;
        case (state_q)
            ST_WAIT_TX: tx_ready_o = owner_oh;
            ST_WR_TX: begin
                m_valid_o = 1'b1;
                m_addr_o  = SPI_BASE + OFF_TXDATA;
                m_wdata_o = {24'h0, byte_q};
                m_wmask_o = 4'b0001;
            end
            ST_WR_CTRL: begin
                m_valid_o = 1'b1;
                m_addr_o  = SPI_BASE + OFF_CTRL;
                m_wdata_o = ctrl_word(clkdiv_q, 1'b1, 1'b1);
                m_wmask_o = 4'b0011;
            end
            ST_POLL: begin
                m_valid_o = 1'b1;
                m_addr_o  = SPI_BASE + OFF_STATUS;
            end
            ST_RD_RX: begin
                m_valid_o = 1'b1;
                m_addr_o  = SPI_BASE + OFF_RXDATA;
            end
            ST_CLR: begin
                m_valid_o = 1'b1;
                m_addr_o  = SPI_BASE + OFF_STATUS;
                m_wdata_o = 32'h0000_0002;
                m_wmask_o = 4'b0001;
            end
            ST_ABORT: begin
                // Disable the block; START left low so nothing new is launched
                m_valid_o = 1'b1;
                m_addr_o  = SPI_BASE + OFF_CTRL;
                m_wdata_o = ctrl_word(clkdiv_q, 1'b0, 1'b0);
                m_wmask_o = 4'b0011;
            end
            default: ;
        endcase
    end

    assign gnt_o      = gnt_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign err_o      = err_q;

endmodule

// File: doc/spi_mmio_arbiter.md
# spi_mmio_arbiter

Bus-master sequencer that shares the SPI MMIO peripheral between two byte-stream requesters. It owns the peripheral's memory-mapped port and runs the per-byte register sequence for each byte: load TXDATA, start, poll STATUS, read RXDATA, clear DONE. Grants are round-robin and locked for a whole burst. Software no longer polls the SPI registers directly.

## Interface
- SPI_BASE, 32'h2000_1000: base address of the SPI register block.
- TIMEOUT, 16'd4096: maximum number of POLL cycles per byte before the byte is aborted.
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- cfg_clkdiv  in  8  SCLK divider. Sampled when a grant is issued and held for the whole burst.
- req  in  2  per-requester burst request, level-sensitive.
- gnt  out  2  one-hot grant, registered.
- tx_valid  in  2  per-requester TX byte valid.
- tx_data  in  16  TX bytes; requester i drives [8i+7:8i].
- tx_ready  out  2  TX accept, asserted only toward the owner.
- rx_valid  out  2  one-cycle RX byte pulse to the owner.
- rx_data  out  8  received byte, shared; valid only with rx_valid.
- err  out  2  one-cycle timeout pulse to the owner.
- m_valid  out  1  peripheral access strobe; each access completes in one cycle.
- m_addr  out  32  word address.
- m_wdata  out  32  write data.
- m_wmask  out  4  byte-enable mask; 0 means read.
- m_rdata  in  32  combinational read data, sampled in the same cycle as m_valid.

## Operation
- Register offsets: CTRL 0x00 (bit0 EN, bit1 START, bits[15:8] CLKDIV); TXDATA 0x04; RXDATA 0x08; STATUS 0x0C (bit0 BUSY, bit1 DONE; writing 1 to bit1 clears DONE).
- States: IDLE, WAIT_TX, WR_TX, WR_CTRL, POLL, RD_RX, CLR, ABORT.
- IDLE: if any req is high, grant it. If both are high, grant the requester that is not last_owner. last_owner resets to 1, so requester 0 wins the first tie. Latch cfg_clkdiv. Go to WAIT_TX.
- WAIT_TX:
  - tx_ready[owner]=1.
  - If tx_valid[owner] is high, latch the byte and go to WR_TX.
  - Else if req[owner] is low, clear gnt, set last_owner=owner, go to IDLE.
  - tx_valid takes priority when it is high in the same cycle that req drops.
- WR_TX: write BASE+0x04, wdata={24'h0,byte}, wmask 4'b0001.
- WR_CTRL: write BASE+0x00, wdata={16'h0,clkdiv,6'h0,2'b11}, wmask 4'b0011.
- POLL:
  - Read BASE+0x0C every cycle. The timeout counter is zeroed on entry.
  - If m_rdata[1]=1, go to RD_RX.
  - Else if count==TIMEOUT-1, go to ABORT.
  - Else increment the counter.
- RD_RX: read BASE+0x08 and register m_rdata[7:0] into rx_data.
- CLR: write BASE+0x0C, wdata 32'h2, wmask 4'b0001. Pulse rx_valid[owner]. Go to WAIT_TX.
- ABORT:
  - Write CTRL with wdata={16'h0,clkdiv,8'h00} (EN=0).
  - Pulse err[owner].
  - Drop gnt, set last_owner=owner, go to IDLE.
  - No rx_valid is produced for the aborted byte.
- A req drop during WR_TX..CLR is ignored; the byte always completes or aborts first.
- In IDLE and WAIT_TX: m_valid=0 and m_addr/m_wdata/m_wmask=0.

## Timing
- Reset values:
  - All outputs are 0.
  - State IDLE, last_owner=1, timeout counter 0, rx_data 8'h00.
  - Reset asserted mid-burst returns to IDLE immediately; no clear or abort write is issued.
- Grant: gnt is high in the cycle after req is sampled in IDLE, and tx_ready is high in that same cycle.
- Per-byte sequence: TX handshake in cycle t, WR_TX t+1, WR_CTRL t+2, POLL from t+3.
- rx_valid is high in the cycle after the RD_RX cycle, i.e. the CLR cycle. tx_ready next rises in the cycle after CLR.
- Back-to-back bytes: about 16*(clkdiv+1)+8 cycles per byte.
- Arbitration gap: at least one IDLE cycle between bursts. gnt is never two-hot.
- tx_ready, m_valid, m_addr, m_wdata and m_wmask are combinational decodes of the registered state and data.

## Structure
- spi_mmio_pkg holds:
  - register offsets (CTRL/TXDATA/RXDATA/STATUS);
  - CTRL and STATUS bit positions;
  - the state enum.
- Sub-module rr_arb2: two-input round-robin pick from req and last_owner, purely combinational. The grant register lives in the parent.

## Test plan
- Single requester: req[0]=1, one byte 8'hA5, MISO looped to MOSI through the SPI model → accesses in order WR 0x04 (0xA5), WR 0x00 (0x0203), POLLs, RD 0x08, WR 0x0C (0x2); rx_valid[0] pulses with rx_data=8'hA5.
- Burst: requester 1 sends 8'h01,8'h02,8'h03 with cfg_clkdiv=4 → three rx_valid[1] pulses in order; gnt[1] stays high until req[1] drops after the third byte.
- Tie: req=2'b11 from reset → gnt=2'b01 first; after requester 0 releases, gnt=2'b10; with req=2'b11 again, gnt=2'b01.
- Timeout: STATUS model never sets DONE, TIMEOUT=16 → 16 POLL reads, then CTRL write 0x0200 (clkdiv=2, EN=0), err[owner] pulses once, gnt returns to 0.
- req[0] dropped during POLL → the byte completes with rx_valid[0]; gnt is released only from WAIT_TX.
- resetn pulsed low during POLL → all outputs 0 in the same cycle; the next req is granted normally.
